// File: rtl/clock_div_ctrl.sv
// rtl/clock_div_ctrl.sv - round-robin divisor-update controller, commits on slow-clock falling edge
// Optional forced-commit timeout is enabled by defining DIVCTRL_TIMEOUT_EN.
module clock_div_ctrl #(
  parameter int NREQ    = 2,
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 131071
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*DIV_W-1:0] i_div_bus,
  input  logic                  i_slow_clk,
  output logic [DIV_W-1:0]      o_divisor,
  output logic [NREQ-1:0]       o_ack,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int GW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("clock_div_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_last_grant;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_grant_idx;
  logic [GW-1:0]    w_cand;
  logic             w_found;
  logic [DIV_W-1:0] r_pending;
  logic [DIV_W-1:0] r_divisor;
  logic [DIV_W-1:0] w_req_div;
  logic             r_err;
  logic             r_tmo;
  logic             r_slow_q;
  logic             w_fall;
  logic             w_idle_div;
  logic             w_force;
  logic             w_commit;
  logic             w_reject;
  logic             w_same;

  // Round-robin search starting just above the last grant, wrapping at NREQ-1.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = r_last_grant;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = (w_cand == GW'(NREQ - 1)) ? '0 : w_cand + 1'b1;
      if (!w_found && i_req[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_req_div  = i_div_bus[w_grant_idx*DIV_W +: DIV_W];
  assign w_reject   = (w_req_div < DIV_W'(2));
  assign w_same     = (w_req_div == r_divisor);
  assign w_fall     = r_slow_q & ~i_slow_clk;
  assign w_idle_div = (r_divisor < DIV_W'(2));
  assign w_commit   = w_fall | w_idle_div | w_force;

`ifdef DIVCTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Held at zero outside WAIT_EDGE, so it starts from zero on every entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || r_state != WAIT_EDGE) r_cnt <= '0;
    else                                  r_cnt <= r_cnt + 1'b1;
  end

  assign w_force = (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ack       = '0;
    o_err       = 1'b0;
    o_timeout   = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nxt = (w_reject || w_same) ? DONE : WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (w_commit) w_state_nxt = DONE;
      end
      DONE: begin
        o_ack[r_grant] = 1'b1;
        o_err          = r_err;
        o_timeout      = r_tmo;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_grant <= GW'(NREQ - 1);
      r_grant      <= '0;
      r_pending    <= '0;
      r_divisor    <= '0;
      r_err        <= 1'b0;
      r_tmo        <= 1'b0;
      r_slow_q     <= 1'b0;
    end else begin
      r_slow_q <= i_slow_clk;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_err        <= w_reject;
            r_tmo        <= 1'b0;
            r_pending    <= w_req_div;
          end
        end
        WAIT_EDGE: begin
          if (w_commit) begin
            r_divisor <= r_pending;
            r_tmo     <= w_force & ~w_fall & ~w_idle_div;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_divisor = r_divisor;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb/tb_clock_div_ctrl.sv - directed self-checking bench for clock_div_ctrl
module tb_clock_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] div_bus;
  logic        slow;
  logic [15:0] divisor;
  logic [1:0]  ack;
  logic        err;
  logic        busy;
  logic        tmo;

  int checks;
  int errors;

  clock_div_ctrl #(.NREQ(2), .DIV_W(16), .TIMEOUT(50)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_div_bus  (div_bus),
    .i_slow_clk (slow),
    .o_divisor  (divisor),
    .o_ack      (ack),
    .o_err      (err),
    .o_busy     (busy),
    .o_timeout  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = 2'b00;
    div_bus = '0;
    slow    = 1'b0;
    tick();
    tick();
    check("rst_divisor", divisor, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_timeout", tmo, 0);
    rst_n = 1'b1;

    // Requester 0 wins first; divider idle so commit is immediate in WAIT_EDGE.
    req = 2'b01; div_bus[15:0] = 16'd4;
    tick();
    check("idle_wait_busy", busy, 1);
    check("idle_wait_ack", ack, 0);
    check("idle_wait_div", divisor, 0);
    tick();
    check("idle_commit_div", divisor, 4);
    check("idle_commit_ack", ack, 1);
    check("idle_commit_err", err, 0);
    req = 2'b00;
    tick();
    check("idle_ack_pulse", ack, 0);
    check("idle_busy_clr", busy, 0);

    // Running divider: change waits for slow-clock 1->0.
    slow = 1'b1; req = 2'b10; div_bus[31:16] = 16'd100;
    tick();
    check("run_wait_div", divisor, 4);
    check("run_wait_busy", busy, 1);
    tick();
    check("run_hold_div", divisor, 4);
    check("run_hold_ack", ack, 0);
    slow = 1'b0;
    tick();
    check("run_commit_div", divisor, 100);
    check("run_commit_ack", ack, 2);
    check("run_commit_tmo", tmo, 0);
    req = 2'b00;
    tick();
    check("run_ack_clr", ack, 0);

    // Rejects: divisor 1 then 0.
    req = 2'b01; div_bus[15:0] = 16'd1;
    tick();
    check("rej1_ack", ack, 1);
    check("rej1_err", err, 1);
    check("rej1_div", divisor, 100);
    req = 2'b00;
    tick();
    check("rej1_err_clr", err, 0);
    req = 2'b01; div_bus[15:0] = 16'd0;
    tick();
    check("rej0_ack", ack, 1);
    check("rej0_err", err, 1);
    check("rej0_div", divisor, 100);
    req = 2'b00;
    tick();

    // Same value: immediate ack, no change; leaves last grant at requester 1.
    req = 2'b10; div_bus[31:16] = 16'd100;
    tick();
    check("same_ack", ack, 2);
    check("same_err", err, 0);
    check("same_div", divisor, 100);
    req = 2'b00;
    tick();

    // Simultaneous requests alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      req = 2'b11; div_bus = {16'd100, 16'd100};
      tick();
      check("rr_ack", ack, (k % 2 == 0) ? 1 : 2);
      req = 2'b00;
      tick();
    end

    // Reset during WAIT_EDGE discards the pending divisor.
    slow = 1'b0; req = 2'b01; div_bus[15:0] = 16'd101;
    tick();
    check("rstw_busy", busy, 1);
    check("rstw_div", divisor, 100);
    rst_n = 1'b0; req = 2'b00;
    tick();
    check("rstw_div_clr", divisor, 0);
    check("rstw_busy_clr", busy, 0);
    check("rstw_ack", ack, 0);
    rst_n = 1'b1;
    tick();
    check("rstw_no_ack", ack, 0);
    check("rstw_idle", busy, 0);

    // Bring divisor to 4 via idle path, then hold the slow clock high.
    req = 2'b01; div_bus[15:0] = 16'd4;
    tick();
    tick();
    check("pre_div", divisor, 4);
    req = 2'b00;
    tick();
    slow = 1'b1; req = 2'b01; div_bus[15:0] = 16'd8;
    tick();
    req = 2'b00;
    for (int k = 0; k < 49; k++) tick();
    check("stall_div", divisor, 4);
    check("stall_ack", ack, 0);
    check("stall_busy", busy, 1);
    tick();
`ifdef DIVCTRL_TIMEOUT_EN
    check("tmo_div", divisor, 8);
    check("tmo_ack", ack, 1);
    check("tmo_flag", tmo, 1);
    tick();
`else
    check("notmo_div", divisor, 4);
    check("notmo_ack", ack, 0);
    for (int k = 0; k < 20; k++) tick();
    check("notmo_wait", busy, 1);
    slow = 1'b0;
    tick();
    check("notmo_commit_div", divisor, 8);
    check("notmo_commit_ack", ack, 1);
    check("notmo_commit_tmo", tmo, 0);
    tick();
`endif
    check("end_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
